my_ram_16k: RTL and testbench

MY_RAM_16K -- requirements
Module: my_ram_16k

---
 rtl/my_ram_16k_pkg.sv | 20 ++
 rtl/my_ram_4k.sv | 37 +++
 rtl/my_ram_16k.sv | 43 ++++
 tb/tb_my_ram_16k.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/my_ram_16k_pkg.sv
// my_ram_16k_pkg
//   Shared constants and types for the 16K x 16 RAM and its 4K x 16 banks.
//   DATA_W      : word width (16)
//   ADDR_W      : full word address width (14, 16384 words)
//   BANK_ADDR_W : per-bank address width (12, 4096 words)
//   NUM_BANKS   : number of 4K banks making up the 16K array
package my_ram_16k_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 14;
  localparam int BANK_ADDR_W = 12;
  localparam int NUM_BANKS   = 4;
  localparam int BANK_WORDS  = 1 << BANK_ADDR_W;

  typedef logic [DATA_W-1:0]             word_t;
  typedef logic [ADDR_W-1:0]             addr_t;
  typedef logic [BANK_ADDR_W-1:0]        bank_addr_t;
  typedef logic [ADDR_W-BANK_ADDR_W-1:0] bank_t;

endpackage

// File: rtl/my_ram_4k.sv
// my_ram_4k
//   4096 x 16 RAM bank with combinational read and synchronous write.
//   A reset edge clears every word; reset takes priority over load.
//   out   : read data, word at addr (combinational)
//   in    : write data
//   addr  : word address for read and write
//   clk   : rising-edge clock
//   load  : write enable, active-high
//   reset : synchronous active-high clear of all contents
module my_ram_4k
  import my_ram_16k_pkg::*;
(
  output logic [DATA_W-1:0]      out,
  input  logic [DATA_W-1:0]      in,
  input  logic [BANK_ADDR_W-1:0] addr,
  input  logic                   clk,
  input  logic                   load,
  input  logic                   reset
);

  word_t mem [BANK_WORDS];

  // The whole array must read zero after a single reset edge, so the
  // storage is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BANK_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[addr] <= in;
    end
  end

  assign out = mem[addr];

endmodule

// File: rtl/my_ram_16k.sv
// my_ram_16k
//   16384 x 16 RAM built from four 4K banks. addr[13:12] picks the bank:
//   it steers load to exactly one bank and selects that bank's read data.
//   addr[11:0] addresses all banks in parallel.
//   out   : read data, word at addr (combinational, zero latency)
//   in    : write data
//   addr  : word address for read and write
//   clk   : rising-edge clock
//   load  : write enable, active-high
//   reset : synchronous active-high clear of all 16384 words
module my_ram_16k
  import my_ram_16k_pkg::*;
(
  output logic [DATA_W-1:0] out,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              clk,
  input  logic              load,
  input  logic              reset
);

  bank_t      bank;
  bank_addr_t bank_addr;
  word_t      bank_out [NUM_BANKS];

  assign bank      = addr[ADDR_W-1:BANK_ADDR_W];
  assign bank_addr = addr[BANK_ADDR_W-1:0];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    my_ram_4k u_bank (
      .out   (bank_out[b]),
      .in    (in),
      .addr  (bank_addr),
      .clk   (clk),
      .load  (load && (bank == bank_t'(b))),
      .reset (reset)
    );
  end

  // 4:1 read mux on the bank select bits
  assign out = bank_out[bank];

endmodule

// File: tb/tb_my_ram_16k.sv
// tb_my_ram_16k
//   Scoreboard bench for my_ram_16k. The stimulus process drives one
//   operation per clock, pushes the value the RAM must present during that
//   cycle into a queue, and updates an associative-array model of the
//   memory at the clock edge. A monitor pops and compares on each falling
//   edge while a check is pending.
module tb_my_ram_16k;

  logic [15:0] out;
  logic [15:0] in;
  logic [13:0] addr;
  logic        clk;
  logic        load;
  logic        reset;

  my_ram_16k dut (
    .out   (out),
    .in    (in),
    .addr  (addr),
    .clk   (clk),
    .load  (load),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    logic [13:0] a;
    string       name;
  } chk_t;

  chk_t        exp_q[$];
  logic [15:0] model [int];
  int          vectors = 0;
  int          miscompares = 0;

  // Value of a word after the first reset: unwritten words read zero.
  function automatic logic [15:0] model_rd(input logic [13:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    return 16'h0000;
  endfunction

  // One clock of stimulus. A short burst of unrelated input activity
  // precedes the real drive to show between-edge changes have no effect.
  task automatic step(input logic r, input logic l, input logic [15:0] d,
                      input logic [13:0] a, input logic chk, input string name);
    chk_t c;
    load  = 1'b1;
    in    = 16'(~d);
    addr  = 14'(~a);
    #1;
    reset = r;
    load  = l;
    in    = d;
    addr  = a;
    if (chk) begin
      c.exp  = model_rd(a);
      c.a    = a;
      c.name = name;
      exp_q.push_back(c);
    end
    @(posedge clk);
    if (r) model.delete();
    else if (l) model[int'(a)] = d;
    #1;
  endtask

  task automatic rd(input logic [13:0] a, input string name);
    step(1'b0, 1'b0, 16'($urandom), a, 1'b1, name);
  endtask

  always @(negedge clk) begin
    chk_t c;
    if (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      vectors++;
      if (out !== c.exp) begin
        miscompares++;
        $display("FAIL %s addr=%h: got %h expected %h", c.name, c.a, out, c.exp);
      end
    end
  end

  logic [13:0] pool [8];

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    in    = '0;
    addr  = '0;
    pool = '{14'h0000, 14'h0FFF, 14'h1000, 14'h1FFF,
             14'h2000, 14'h2FFF, 14'h3000, 14'h3FFF};
    @(posedge clk);
    #1;

    // Reset edge, then every address reads zero
    step(1'b1, 1'b0, 16'h0, 14'd0, 1'b0, "");
    rd(14'd0,     "rst_a0");
    rd(14'd5000,  "rst_a5000");
    rd(14'd16383, "rst_a16383");

    // Basic writes, then read back
    step(1'b0, 1'b1, 16'd2, 14'd0,                1'b0, "");
    step(1'b0, 1'b1, 16'd9, 14'b10000110100111,   1'b0, "");
    step(1'b0, 1'b1, 16'd1, 14'b11111111111111,   1'b0, "");
    rd(14'd0,              "wr_a0");
    rd(14'b10000110100111, "wr_a21a7");
    rd(14'b11111111111111, "wr_a3fff");

    // Bank boundary
    step(1'b0, 1'b1, 16'hAAAA, 14'h0FFF, 1'b0, "");
    step(1'b0, 1'b1, 16'h5555, 14'h1000, 1'b0, "");
    rd(14'h0FFF, "bnd_0fff");
    rd(14'h1000, "bnd_1000");
    rd(14'd0,    "bnd_a0");

    // load low holds contents regardless of in
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'hFFFF, 14'd0, 1'b1, "hold_a0");

    // Same-cycle write/read: old value before the edge, new after
    step(1'b0, 1'b1, 16'h1234, 14'h0ABC, 1'b1, "wr1_pre");
    step(1'b0, 1'b1, 16'h4321, 14'h0ABC, 1'b1, "wr2_pre");
    rd(14'h0ABC, "wr2_post");

    // Reset wins over a simultaneous write
    step(1'b1, 1'b1, 16'd7, 14'd3, 1'b0, "");
    rd(14'd3,              "rstpri_a3");
    rd(14'd0,              "rstpri_a0");
    rd(14'b10000110100111, "rstpri_a21a7");
    rd(14'h3FFF,           "rstpri_a3fff");
    rd(14'h0FFF,           "rstpri_a0fff");
    rd(14'h1000,           "rstpri_a1000");
    rd(14'h0ABC,           "rstpri_a0abc");

    // Aliasing: same low bits in every bank hold distinct data
    for (int b = 0; b < 4; b++)
      step(1'b0, 1'b1, 16'(16'hB000 + b), {2'(b), 12'h123}, 1'b0, "");
    for (int b = 0; b < 4; b++) rd({2'(b), 12'h123}, "alias");

    // Randomised traffic, mostly on a small address pool so reads hit writes
    for (int i = 0; i < 400; i++) begin
      logic [13:0] a;
      logic        l;
      logic        r;
      a = ($urandom_range(0, 3) == 0) ? 14'($urandom) : pool[$urandom_range(0, 7)];
      l = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 59) == 0);
      step(r, l, 16'($urandom), a, 1'b1, "rand");
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending checks expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
